// File: rtl/intt2_gs_butterfly_pkg.sv
// Shared constants and helpers for the INTT Gentleman-Sande butterfly datapath.
// The modulus and Barrett constants match the forward Cooley-Tukey butterfly.
package intt2_gs_butterfly_pkg;

    localparam int DW  = 33;
    localparam int K   = 32;
    localparam int LAT = 5;

    localparam logic [DW-1:0] Q    = 33'd4294967291;
    localparam logic [DW-1:0] MU   = 33'd4294967301;
    localparam logic [DW-1:0] INV2 = (Q + 33'd1) / 33'd2;

    // Modular halving of v < Q: add Q to odd values so the shift is exact.
    function automatic logic [DW-1:0] halve_mod(input logic [DW-1:0] v);
        logic [DW:0] t;
        t = {1'b0, v} + (v[0] ? {1'b0, Q} : {(DW+1){1'b0}});
        return DW'(t >> 1);
    endfunction

endpackage

// File: rtl/intt2_gs_butterfly_barrett.sv
// Three-cycle Barrett reduction of a 2*DW-bit product modulo Q, with a valid bit
// carried alongside the data. Shared with the forward butterfly.
module barrett_reduce_pipe
    import intt2_gs_butterfly_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [2*DW-1:0] p,
    output logic            out_valid,
    output logic [DW-1:0]   r
);

    localparam logic [2*DW-1:0] MU_W = (2*DW)'(MU);
    localparam logic [2*DW-1:0] Q_W  = (2*DW)'(Q);
    localparam logic [K+1:0]    Q_R  = (K+2)'(Q);

    logic [2*DW-1:0] t3;
    logic [2*DW-1:0] p3;
    logic [2*DW-1:0] qq;
    logic [K+1:0]    r4;
    logic [K+1:0]    r_a;
    logic [K+1:0]    r_b;
    logic            v3;
    logic            v4;

    // NOTE: every variable is assigned on every path through always_comb, so no latch is inferred.
    always_comb begin
        qq  = (t3 >> (K+1)) * Q_W;
        r_a = (r4  >= Q_R) ? r4  - Q_R : r4;
        r_b = (r_a >= Q_R) ? r_a - Q_R : r_a;
    end

    // The estimate undershoots the quotient by at most 2, so R < 3Q fits in K+2 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            t3        <= '0;
            p3        <= '0;
            v3        <= 1'b0;
            r4        <= '0;
            v4        <= 1'b0;
            r         <= '0;
            out_valid <= 1'b0;
        end else begin
            t3        <= (p >> (K-1)) * MU_W;
            p3        <= p;
            v3        <= in_valid;
            r4        <= (K+2)'(p3 - qq);
            v4        <= v3;
            r         <= DW'(r_b);
            out_valid <= v4;
        end
    end

endmodule

// File: rtl/intt2_gs_butterfly.sv
// Pipelined radix-2 Gentleman-Sande INTT butterfly: xout = (x+y)*s, yout = (x-y)*w*s mod Q,
// with s = 1/2 mod Q when half is set. One operation per cycle, five-cycle latency.
module intt2_gs_butterfly
    import intt2_gs_butterfly_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] xin,
    input  logic [DW-1:0] yin,
    input  logic [DW-1:0] wr,
    input  logic          half,
    output logic [DW-1:0] xout,
    output logic [DW-1:0] yout,
    output logic          valid
);

    logic [DW:0]     sum_w;
    logic [DW-1:0]   s_next;
    logic [DW-1:0]   d_next;

    logic [DW-1:0]   s1, d1, w1;
    logic            h1, v1;
    logic [2*DW-1:0] p2;
    logic [DW-1:0]   s2, s3, s4, s5;
    logic            h2, h3, h4, h5;
    logic            v2;
    logic            v5;
    logic [DW-1:0]   res5;

    always_comb begin
        sum_w  = {1'b0, xin} + {1'b0, yin};
        s_next = (sum_w >= {1'b0, Q}) ? DW'(sum_w - {1'b0, Q}) : DW'(sum_w);
        d_next = (xin < yin) ? xin - yin + Q : xin - yin;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0; d1 <= '0; w1 <= '0; h1 <= 1'b0; v1 <= 1'b0;
            p2 <= '0; s2 <= '0; h2 <= 1'b0; v2 <= 1'b0;
            s3 <= '0; s4 <= '0; s5 <= '0;
            h3 <= 1'b0; h4 <= 1'b0; h5 <= 1'b0;
        end else begin
            s1 <= s_next;
            d1 <= d_next;
            w1 <= wr;
            h1 <= half;
            v1 <= en;
            p2 <= (2*DW)'(d1) * (2*DW)'(w1);
            s2 <= s1;
            h2 <= h1;
            v2 <= v1;
            // Sum and half flag ride along until the reduced product is ready.
            s3 <= s2; s4 <= s3; s5 <= s4;
            h3 <= h2; h4 <= h3; h5 <= h4;
        end
    end

    barrett_reduce_pipe u_reduce (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v2),
        .p         (p2),
        .out_valid (v5),
        .r         (res5)
    );

    // Outputs hold their last result across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            xout  <= '0;
            yout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= v5;
            if (v5) begin
                xout <= h5 ? halve_mod(s5)   : s5;
                yout <= h5 ? halve_mod(res5) : res5;
            end
        end
    end

endmodule

// File: tb/tb_intt2_gs_butterfly.sv
// Scoreboard bench for intt2_gs_butterfly: an independent modular-arithmetic model
// queues expected results with their due cycle; a monitor checks them as valid arrives.
module tb_intt2_gs_butterfly;

    localparam int DW  = 33;
    localparam int LAT = 5;
    localparam longint unsigned QM    = 64'd4294967291;
    localparam longint unsigned INV2M = (QM + 64'd1) / 64'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [DW-1:0] xin;
    logic [DW-1:0] yin;
    logic [DW-1:0] wr;
    logic          half;
    logic [DW-1:0] xout;
    logic [DW-1:0] yout;
    logic          valid;

    typedef struct {
        longint unsigned x;
        longint unsigned y;
        int              due;
    } exp_t;

    exp_t sb[$];
    int   edges   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    intt2_gs_butterfly dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .xin   (xin),
        .yin   (yin),
        .wr    (wr),
        .half  (half),
        .xout  (xout),
        .yout  (yout),
        .valid (valid)
    );

    task automatic check(input string tag, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edges);
        end
    endtask

    // Halving is modelled as multiplication by the modular inverse of 2.
    function automatic exp_t model(input longint unsigned x, input longint unsigned y,
                                   input longint unsigned w, input bit h, input int due);
        exp_t e;
        longint unsigned s, d, t;
        s = (x + y) % QM;
        d = (x + QM - y) % QM;
        t = (d * w) % QM;
        if (h) begin
            s = (s * INV2M) % QM;
            t = (t * INV2M) % QM;
        end
        e.x   = s;
        e.y   = t;
        e.due = due;
        return e;
    endfunction

    task automatic drive(input bit rst, input bit e, input longint unsigned x,
                         input longint unsigned y, input longint unsigned w, input bit h);
        @(negedge clk);
        assert (x < QM && y < QM && w < QM) else $error("operand out of range");
        reset = rst;
        en    = e;
        xin   = DW'(x);
        yin   = DW'(y);
        wr    = DW'(w);
        half  = h;
        if (rst) sb.delete();
        else if (e) sb.push_back(model(x, y, w, h, edges + 1 + LAT));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    function automatic longint unsigned pick_op();
        case ($urandom_range(7))
            0:       return 0;
            1:       return QM - 1;
            2:       return 1;
            default: return longint'($urandom_range(32'd4294967290, 0));
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t e;
        edges++;
        #1;
        if (valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", valid, 0);
            end else begin
                e = sb.pop_front();
                check("xout", xout, e.x);
                check("yout", yout, e.y);
                check("latency", edges, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= edges) begin
            check("missed_valid", valid, 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; xin = '0; yin = '0; wr = '0; half = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
        @(posedge clk); #2;
        check("rst_valid", valid, 0);
        check("rst_xout", xout, 0);
        check("rst_yout", yout, 0);
        idle(2);

        // Isolated basic op, then negative difference.
        drive(1'b0, 1'b1, 5, 3, 2, 1'b0);
        idle(8);
        drive(1'b0, 1'b1, 3, 5, 1, 1'b0);
        idle(8);

        // Wrap-around operands back to back.
        drive(1'b0, 1'b1, QM - 1, QM - 1, QM - 1, 1'b0);
        drive(1'b0, 1'b1, 0, 1, QM - 1, 1'b0);
        idle(8);

        // Halving, including an odd sum, and alternating half back to back.
        drive(1'b0, 1'b1, 5, 3, 2, 1'b1);
        drive(1'b0, 1'b1, 3, 0, 1, 1'b1);
        drive(1'b0, 1'b1, 3, 0, 1, 1'b0);
        drive(1'b0, 1'b1, QM - 1, 0, QM - 1, 1'b1);
        idle(8);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) == 0) idle(1 + $urandom_range(2));
            drive(1'b0, 1'b1, pick_op(), pick_op(), pick_op(), 1'($urandom_range(1)));
        end
        idle(10);

        // Reset while three ops are in flight; the third is issued during reset.
        drive(1'b0, 1'b1, 7, 2, 9, 1'b0);
        drive(1'b0, 1'b1, 11, 4, 6, 1'b1);
        drive(1'b1, 1'b1, 13, 1, 5, 1'b0);
        @(posedge clk); #2;
        check("flush_valid", valid, 0);
        check("flush_xout", xout, 0);
        check("flush_yout", yout, 0);
        drive(1'b0, 1'b1, 100, 250, 3, 1'b0);
        idle(12);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        check("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
